// File: rtl/ham_chk_collect.sv
// Collector behind the Hamming(8,4) checker: FIFO-buffers corrected nibbles, counts corrected/fatal errors, raises a sticky irq.
// Optional macro HAM_COLLECT_DROP_FATAL_EN: fatal words are counted but not buffered, and fatal_o is tied low.
module ham_chk_collect #(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       data_i,
  input  logic             error_i,
  input  logic             fatal_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [3:0]       data_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] cnt_corr_o,
  output logic [CNT_W-1:0] cnt_fatal_o,
  input  logic             clr_cnt_i,
  output logic             irq_o,
  input  logic             irq_clr_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESH - 1);
  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       PEND    = 1'b1;

`ifdef HAM_COLLECT_DROP_FATAL_EN
  localparam int EW = 4;
`else
  localparam int EW = 5;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_fatal_q, cnt_fatal_d;
  logic [0:0]    state_q, state_d;

  logic          full, empty, push, pop, wr_en, corr_inc, fatal_inc, irq_set;
  logic [EW-1:0] wr_entry, head;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ready_o = !full;
  assign valid_o = !empty;
  assign push    = valid_i && !full;
  assign pop     = ready_i && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign data_o  = valid_o ? head[3:0] : 4'h0;

`ifdef HAM_COLLECT_DROP_FATAL_EN
  assign wr_en    = push && !fatal_i;
  assign wr_entry = data_i;
  assign fatal_o  = 1'b0;
`else
  assign wr_en    = push;
  assign wr_entry = {fatal_i, data_i};
  assign fatal_o  = valid_o && head[4];
`endif

  assign fatal_inc = push && fatal_i;
  assign corr_inc  = push && error_i && !fatal_i;
  // Only the THRESH-1 -> THRESH step fires; a cleared or saturated count never does.
  assign irq_set   = fatal_inc || (corr_inc && !clr_cnt_i && (cnt_corr_q == THR_M1));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_comb begin
    cnt_corr_d  = cnt_corr_q;
    cnt_fatal_d = cnt_fatal_q;
    if (clr_cnt_i) begin
      cnt_corr_d  = '0;
      cnt_fatal_d = '0;
    end else begin
      if (corr_inc && (cnt_corr_q != CNT_MAX))   cnt_corr_d  = cnt_corr_q + CNT_ONE;
      if (fatal_inc && (cnt_fatal_q != CNT_MAX)) cnt_fatal_d = cnt_fatal_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (irq_set) state_d = PEND;
      PEND:    if (irq_clr_i && !irq_set) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_corr_q  <= '0;
      cnt_fatal_q <= '0;
      state_q     <= IDLE;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_corr_q  <= cnt_corr_d;
      cnt_fatal_q <= cnt_fatal_d;
      state_q     <= state_d;
    end
  end

  assign cnt_corr_o  = cnt_corr_q;
  assign cnt_fatal_o = cnt_fatal_q;
  assign irq_o       = (state_q == PEND);

endmodule

// File: tb/tb_ham_chk_collect.sv
// Self-checking bench for ham_chk_collect: table vectors, directed corner sequences and a random run against a queue model.
module tb_ham_chk_collect;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int THRESH = 16;
  localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef HAM_COLLECT_DROP_FATAL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_i = 1'b0, error_i = 1'b0, fatal_i = 1'b0, ready_i = 1'b0;
  logic clr_cnt_i = 1'b0, irq_clr_i = 1'b0;
  logic [3:0] data_i = 4'h0;
  logic ready_o, valid_o, fatal_o, irq_o;
  logic [3:0] data_o;
  logic [CNT_W-1:0] cnt_corr_o, cnt_fatal_o;

  ham_chk_collect #(.DEPTH(DEPTH), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .error_i(error_i), .fatal_i(fatal_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .fatal_o(fatal_o),
    .cnt_corr_o(cnt_corr_o), .cnt_fatal_o(cnt_fatal_o), .clr_cnt_i(clr_cnt_i),
    .irq_o(irq_o), .irq_clr_i(irq_clr_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: FIFO contents as a queue of {fatal, data}, plain integer counts, irq bit.
  logic [4:0] mq[$];
  int mc = 0;
  int mf = 0;
  bit mirq = 1'b0;

  typedef struct {
    logic v; logic [3:0] d; logic e; logic f; logic rdy;
    logic exp_valid; logic [3:0] exp_data; logic exp_ready;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; applies inputs over one clock edge and advances the model.
  task automatic drive(input logic v, input logic [3:0] d, input logic e, input logic f,
                       input logic rdy, input logic clr, input logic iclr);
    int sz;
    bit push, pop, set_ev;
    valid_i = v; data_i = d; error_i = e; fatal_i = f;
    ready_i = rdy; clr_cnt_i = clr; irq_clr_i = iclr;
    sz = mq.size();
    push = v && (sz < DEPTH);
    pop = rdy && (sz > 0);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push && !(DROP && f)) mq.push_back({f, d});
    set_ev = push && f;
    if (clr) begin
      mc = 0; mf = 0;
    end else if (push) begin
      if (f) begin
        if (mf < MAXC) mf++;
      end else if (e && mc < MAXC) begin
        mc++;
        if (mc == THRESH) set_ev = 1'b1;
      end
    end
    if (set_ev) mirq = 1'b1;
    else if (iclr) mirq = 1'b0;
    $display("cyc v=%0b d=%0h e=%0b f=%0b rdy=%0b clr=%0b iclr=%0b -> valid=%0b data=%0h fat=%0b ready=%0b corr=%0d fatal=%0d irq=%0b",
             v, d, e, f, rdy, clr, iclr, valid_o, data_o, fatal_o, ready_o, cnt_corr_o, cnt_fatal_o, irq_o);
  endtask

  task automatic idle_in();
    valid_i = 0; error_i = 0; fatal_i = 0; ready_i = 0; clr_cnt_i = 0; irq_clr_i = 0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ":ready"}, ready_o, mq.size() < DEPTH);
    chk({tag, ":valid"}, valid_o, mq.size() > 0);
    if (mq.size() > 0) begin
      chk({tag, ":data"}, data_o, mq[0][3:0]);
      chk({tag, ":fatal_o"}, fatal_o, mq[0][4]);
    end
    chk({tag, ":cnt_corr"}, cnt_corr_o, mc);
    chk({tag, ":cnt_fatal"}, cnt_fatal_o, mf);
    chk({tag, ":irq"}, irq_o, mirq);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(0, 4'h0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    vecs[0] = '{1, 4'h3, 0, 0, 0, 1, 4'h3, 1};
    vecs[1] = '{1, 4'h5, 0, 0, 0, 1, 4'h3, 1};
    vecs[2] = '{1, 4'hA, 0, 0, 0, 1, 4'h3, 1};
    vecs[3] = '{0, 4'h0, 0, 0, 1, 1, 4'h5, 1};
    vecs[4] = '{0, 4'h0, 0, 0, 1, 1, 4'hA, 1};
    vecs[5] = '{0, 4'h0, 0, 0, 1, 0, 4'h0, 1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_model("reset");
    chk("reset:data_o", data_o, 4'h0);
    chk("reset:fatal_o", fatal_o, 1'b0);

    // Ordered buffering and show-ahead hold
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].f, vecs[i].rdy, 0, 0);
      chk($sformatf("vec%0d:valid", i), valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d:data", i), data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d:ready", i), ready_o, vecs[i].exp_ready);
      cmp_model($sformatf("vec%0d", i));
    end

    // Full, blocked push, pop frees space, then pointer wrap
    for (int i = 0; i < 4; i++) drive(1, 4'(i + 1), 0, 0, 0, 0, 0);
    chk("full:ready_low", ready_o, 1'b0);
    drive(1, 4'hE, 0, 0, 0, 0, 0);
    cmp_model("full:blocked");
    drive(0, 4'h0, 0, 0, 1, 0, 0);
    chk("full:ready_after_pop", ready_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'(i + 6), 0, 0, 1, 0, 0);
      cmp_model($sformatf("wrap%0d", i));
    end
    drain();
    cmp_model("drained");

    // Corrected-count threshold crossing
    for (int i = 0; i < THRESH; i++) drive(1, 4'(i), 1, 0, 1, 0, 0);
    chk("thr:cnt16", cnt_corr_o, 8'd16);
    chk("thr:irq_set", irq_o, 1'b1);
    drive(0, 4'h0, 0, 0, 1, 0, 1);
    chk("thr:irq_cleared", irq_o, 1'b0);
    drive(1, 4'h1, 1, 0, 1, 0, 0);
    chk("thr:cnt17", cnt_corr_o, 8'd17);
    chk("thr:no_refire", irq_o, 1'b0);
    drain();

    // Fatal push with simultaneous irq clear: set wins
    drive(1, 4'h9, 0, 1, 0, 0, 1);
    chk("fatal:irq", irq_o, 1'b1);
    chk("fatal:cnt", cnt_fatal_o, 8'd1);
    if (DROP) chk("fatal:dropped", valid_o, 1'b0);
    else begin
      chk("fatal:buffered", valid_o, 1'b1);
      chk("fatal:data", data_o, 4'h9);
      chk("fatal:fatal_o", fatal_o, 1'b1);
    end
    cmp_model("fatal");
    drain();

    // Saturation and clear-over-increment priority
    for (int i = 0; i < 300; i++) drive(1, 4'(i), 1, 0, 1, 0, 0);
    chk("sat:cnt255", cnt_corr_o, 8'd255);
    drive(1, 4'h2, 1, 0, 1, 1, 0);
    chk("sat:clr_wins", cnt_corr_o, 8'd0);
    cmp_model("sat");
    drain();

    // Asynchronous reset with entries buffered and irq pending
    for (int i = 0; i < 3; i++) drive(1, 4'(i + 4), 0, 0, 0, 0, 0);
    chk("arst:pre_irq", irq_o, 1'b1);
    cmp_model("arst:pre");
    idle_in();
    #2 reset = 1'b1;
    #1;
    chk("arst:valid", valid_o, 1'b0);
    chk("arst:ready", ready_o, 1'b1);
    chk("arst:corr", cnt_corr_o, 8'd0);
    chk("arst:fatal", cnt_fatal_o, 8'd0);
    chk("arst:irq", irq_o, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    mq.delete(); mc = 0; mf = 0; mirq = 1'b0;
    cmp_model("arst:post");
    drive(1, 4'hC, 0, 0, 0, 0, 0);
    chk("arst:resume_valid", valid_o, 1'b1);
    chk("arst:resume_data", data_o, 4'hC);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 15) == 0);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ham_chk_collect.md
Name: ham_chk_collect

Overview:
- Sits directly downstream of the Hamming(8,4) checker.
- Accepts the checker's corrected nibble with its error/fatal flags over a valid/ready handshake, and buffers words in a small FIFO toward the consumer.
- Keeps saturating counts of corrected and uncorrectable (fatal) errors.
- Raises a sticky interrupt on a fatal error or when the corrected-error count reaches a threshold.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of each error counter.
- THRESH, 16, corrected-error count that raises irq_o; must satisfy 1 <= THRESH <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  upstream word valid
- ready_o  out  1  collector can accept a word
- data_i  in  4  corrected data from the checker
- error_i  in  1  checker reported an error
- fatal_i  in  1  checker reported an uncorrectable error
- valid_o  out  1  head FIFO entry valid
- ready_i  in  1  downstream accepts the head entry
- data_o  out  4  head entry data
- fatal_o  out  1  head entry was fatal
- cnt_corr_o  out  CNT_W  corrected-error count
- cnt_fatal_o  out  CNT_W  fatal-error count
- clr_cnt_i  in  1  synchronous clear of both counters
- irq_o  out  1  sticky interrupt
- irq_clr_i  in  1  synchronous interrupt clear

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is clk, reset port is reset.
- Reset values:
  - FIFO empty; valid_o=0, ready_o=1.
  - data_o=0, fatal_o=0.
  - Both counters 0; irq_o=0.
  - Read/write pointers 0.
- Reset mid-operation discards all buffered words and counts immediately. No handshake completes in a cycle where reset is asserted.
- Input handshake:
  - Push when valid_i && ready_o.
  - ready_o = !full; it is registered-state derived and never depends combinationally on valid_i.
  - data_i, error_i and fatal_i are sampled only on push.
- Output handshake:
  - Pop when valid_o && ready_i.
  - valid_o = !empty.
  - data_o/fatal_o present the head entry show-ahead and hold stable while valid_o && !ready_i.
- Latency: a push into an empty FIFO gives valid_o=1 on the next cycle. There is no combinational bypass.
- Full: ready_o=0, no push. A pop in that cycle frees an entry; ready_o rises the next cycle.
- Empty: valid_o=0; ready_i is ignored.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap DEPTH-1 to 0. Full/empty are resolved with an extra wrap bit or an occupancy counter of log2(DEPTH)+1 bits.
- Error classification, on push only:
  - fatal_i=1 counts as fatal regardless of error_i.
  - error_i=1, fatal_i=0 counts as corrected.
  - Neither set: no count.
- Counters increment by 1 and saturate at 2^CNT_W-1; they do not wrap.
- clr_cnt_i forces both counters to 0 next cycle. It has priority over a same-cycle increment; that event is lost.
- irq_o state machine:
  - IDLE -> PEND on either of:
    - push of a fatal word;
    - cnt_corr_o transitioning from THRESH-1 to THRESH.
  - PEND -> IDLE on irq_clr_i.
  - If a set event and irq_clr_i occur in the same cycle, set wins and the state stays/goes PEND.
  - irq_o = (state==PEND), registered.
  - A saturated or already-past-threshold count does not re-fire; only the crossing does.
  - clr_cnt_i does not clear irq_o.

Optional Feature:
- Macro: HAM_COLLECT_DROP_FATAL_EN.
- Defined:
  - Fatal words are counted and raise irq as normal but are not written into the FIFO. The push is acknowledged and consumes no entry.
  - fatal_o is tied to 0.
- Undefined: fatal words are buffered like any other, with fatal_o=1 on their entry.

Test Plan:
- Reset, then push data 0x3/0x5/0xA with no errors while ready_i=0:
  - valid_o=1 from the cycle after the first push;
  - data_o=0x3 held stable;
  - draining with ready_i=1 yields 0x3, 0x5, 0xA in order;
  - counters stay 0.
- Push 4 words with ready_i=0 (DEPTH=4):
  - ready_o=0 after the fourth push;
  - a fifth valid_i is not accepted;
  - one pop gives ready_o=1 next cycle;
  - pointer wrap is verified over 10 further words.
- Push 16 words with error_i=1, fatal_i=0:
  - cnt_corr_o=16 and irq_o=1 the cycle after the 16th push;
  - irq_clr_i clears it;
  - a 17th corrected word leaves irq_o=0 and cnt_corr_o=17.
- Push a word with fatal_i=1, data 0x9, with irq_clr_i asserted in the same cycle:
  - irq_o=1 next cycle;
  - cnt_fatal_o=1;
  - entry has fatal_o=1 (macro undefined), or nothing is buffered (macro defined).
- Push 300 corrected words with CNT_W=8:
  - cnt_corr_o saturates at 255;
  - clr_cnt_i asserted together with a corrected push gives cnt_corr_o=0 next cycle.
- Assert reset asynchronously with 3 entries buffered and irq_o=1:
  - valid_o=0, ready_o=1, counters 0 and irq_o=0 immediately;
  - normal operation resumes after deassertion.
